ctrl_pipeline: RTL and testbench

Carries the decoded control bundle from the decode stage through the EX, MEM and WB pipeline registers of the MIPS datapath. It sits directly downstream of the opcode control unit and drives the per-stage datapath controls. It also detects load-use hazards (stall plus bubble) and resolves taken branches in EX (flush of the instruction in decode).

---
 rtl/ctrl_pipeline_if.sv | 28 ++
 rtl/ctrl_pipeline.sv | 73 +++++++
 tb/tb_ctrl_pipeline.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if: decode-stage control bundle in; per-stage datapath controls and hazard/branch signals out.
interface ctrl_pipeline_if #(parameter int REG_W = 5, parameter int ALUOP_W = 3);
    logic               id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [REG_W-1:0]   id_rs, id_rt, id_rd;
    logic               ex_zero;
    logic               ex_valid, ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [REG_W-1:0]   ex_dst;
    logic               mem_valid, mem_mem_read, mem_mem_write;
    logic               wb_valid, wb_reg_write, wb_mem_reg;
    logic [REG_W-1:0]   wb_dst;
    logic               stall, flush, pc_src;

    modport master (
        output id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_reg, id_mem_write, id_alu_src, id_reg_write,
               id_alu_op, id_rs, id_rt, id_rd, ex_zero,
        input  ex_valid, ex_alu_src, ex_alu_op, ex_dst, mem_valid, mem_mem_read, mem_mem_write,
               wb_valid, wb_reg_write, wb_mem_reg, wb_dst, stall, flush, pc_src
    );

    modport slave (
        input  id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_reg, id_mem_write, id_alu_src, id_reg_write,
               id_alu_op, id_rs, id_rt, id_rd, ex_zero,
        output ex_valid, ex_alu_src, ex_alu_op, ex_dst, mem_valid, mem_mem_read, mem_mem_write,
               wb_valid, wb_reg_write, wb_mem_reg, wb_dst, stall, flush, pc_src
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID/EX, EX/MEM, MEM/WB control registers with load-use stall and EX branch flush.
module ctrl_pipeline #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ctrl_pipeline_if.slave bus
);
    typedef struct packed {
        logic               valid, reg_dst, branch, mem_read, mem_reg, mem_write, alu_src, reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_W-1:0]   rt, rd;
    } idex_t;

    typedef struct packed {
        logic             valid, mem_read, mem_write, mem_reg, reg_write;
        logic [REG_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic             valid, mem_reg, reg_write;
        logic [REG_W-1:0] dst;
    } memwb_t;

    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [REG_W-1:0] ex_dst;
    logic             pc_src, hazard;

    always_comb begin
        ex_dst = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
        pc_src = idex_q.valid & idex_q.branch & bus.ex_zero;
        hazard = bus.id_valid & idex_q.valid & idex_q.mem_read & (ex_dst != '0) &
                 ((ex_dst == bus.id_rs) | (ex_dst == bus.id_rt));
        // Flush, stall and invalid decode all load an all-zero bubble
        idex_d = (bus.id_valid && !pc_src && !hazard) ? idex_t'{
            valid: 1'b1, reg_dst: bus.id_reg_dst, branch: bus.id_branch, mem_read: bus.id_mem_read,
            mem_reg: bus.id_mem_reg, mem_write: bus.id_mem_write, alu_src: bus.id_alu_src,
            reg_write: bus.id_reg_write, alu_op: bus.id_alu_op, rt: bus.id_rt, rd: bus.id_rd} : '0;
        exmem_d = '{valid: idex_q.valid, mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                    mem_reg: idex_q.mem_reg, reg_write: idex_q.reg_write & (ex_dst != '0), dst: ex_dst};
        memwb_d = '{valid: exmem_q.valid, mem_reg: exmem_q.mem_reg, reg_write: exmem_q.reg_write, dst: exmem_q.dst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_valid      = idex_q.valid;
    assign bus.ex_alu_src    = idex_q.alu_src;
    assign bus.ex_alu_op     = idex_q.alu_op;
    assign bus.ex_dst        = ex_dst;
    assign bus.mem_valid     = exmem_q.valid;
    assign bus.mem_mem_read  = exmem_q.mem_read;
    assign bus.mem_mem_write = exmem_q.mem_write;
    assign bus.wb_valid      = memwb_q.valid;
    assign bus.wb_reg_write  = memwb_q.reg_write;
    assign bus.wb_mem_reg    = memwb_q.mem_reg;
    assign bus.wb_dst        = memwb_q.dst;
    assign bus.pc_src        = pc_src;
    assign bus.flush         = pc_src;
    assign bus.stall         = hazard & ~pc_src;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed vectors against a history-based model of accepted decode bundles.
module tb_ctrl_pipeline;
    typedef struct packed {
        logic       valid, reg_dst, branch, mem_read, mem_reg, mem_write, alu_src, reg_write;
        logic [2:0] alu_op;
        logic [4:0] rs, rt, rd;
    } bun_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs = 0;
    bun_t h [1:3];

    always #5 clk = ~clk;

    ctrl_pipeline_if #(.REG_W(5), .ALUOP_W(3)) bus ();

    ctrl_pipeline #(.REG_W(5), .ALUOP_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dst_of(input bun_t b);
        return b.reg_dst ? b.rd : b.rt;
    endfunction

    function automatic bun_t mk(input logic rdst, br, mr, mreg, mw, as, rw,
                                input logic [2:0] op, input logic [4:0] rs, rt, rd);
        return '{valid: 1'b1, reg_dst: rdst, branch: br, mem_read: mr, mem_reg: mreg, mem_write: mw,
                 alu_src: as, reg_write: rw, alu_op: op, rs: rs, rt: rt, rd: rd};
    endfunction

    task automatic drive(input bun_t b, input logic z);
        bus.id_valid     = b.valid;
        bus.id_reg_dst   = b.reg_dst;
        bus.id_branch    = b.branch;
        bus.id_mem_read  = b.mem_read;
        bus.id_mem_reg   = b.mem_reg;
        bus.id_mem_write = b.mem_write;
        bus.id_alu_src   = b.alu_src;
        bus.id_reg_write = b.reg_write;
        bus.id_alu_op    = b.alu_op;
        bus.id_rs        = b.rs;
        bus.id_rt        = b.rt;
        bus.id_rd        = b.rd;
        bus.ex_zero      = z;
    endtask

    task automatic cyc(input bun_t b, input logic z);
        @(posedge clk);
        #1 drive(b, z);
        #1;
    endtask

    // Model: EX/MEM/WB hold the bundles accepted 1/2/3 cycles ago; outputs follow from the rules
    always @(negedge clk) begin : cmp
        bun_t       cur, e, m, w, acc;
        logic       exp_pc, exp_stall;
        logic [4:0] ed;
        if (!rst_n) for (int i = 1; i <= 3; i++) h[i] = '0;
        cur = '{valid: bus.id_valid, reg_dst: bus.id_reg_dst, branch: bus.id_branch, mem_read: bus.id_mem_read,
                mem_reg: bus.id_mem_reg, mem_write: bus.id_mem_write, alu_src: bus.id_alu_src,
                reg_write: bus.id_reg_write, alu_op: bus.id_alu_op, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd};
        e = h[1];
        m = h[2];
        w = h[3];
        ed = dst_of(e);
        exp_pc = e.valid & e.branch & bus.ex_zero;
        exp_stall = cur.valid & e.valid & e.mem_read & (ed != 0) & ((ed == cur.rs) | (ed == cur.rt)) & ~exp_pc;
        chk("ex_valid", bus.ex_valid, e.valid);
        chk("ex_alu_src", bus.ex_alu_src, e.alu_src);
        chk("ex_alu_op", bus.ex_alu_op, e.alu_op);
        chk("ex_dst", bus.ex_dst, ed);
        chk("mem_valid", bus.mem_valid, m.valid);
        chk("mem_mem_read", bus.mem_mem_read, m.mem_read);
        chk("mem_mem_write", bus.mem_mem_write, m.mem_write);
        chk("wb_valid", bus.wb_valid, w.valid);
        chk("wb_reg_write", bus.wb_reg_write, w.reg_write & (dst_of(w) != 0));
        chk("wb_mem_reg", bus.wb_mem_reg, w.mem_reg);
        chk("wb_dst", bus.wb_dst, dst_of(w));
        chk("pc_src", bus.pc_src, exp_pc);
        chk("flush", bus.flush, exp_pc);
        chk("stall", bus.stall, exp_stall);
        acc = (cur.valid && !exp_pc && !exp_stall) ? cur : '0;
        if (rst_n) begin
            h[3] = h[2];
            h[2] = h[1];
            h[1] = acc;
        end
    end

    initial begin
        bun_t nop, ones, rtype, r0, lw8, lw0, add8, rd0, rs9, beq, add, lwbr, sw;
        nop   = '0;
        ones  = '1;
        rtype = mk(1, 0, 0, 0, 0, 0, 1, 3'd7, 5'd1, 5'd2, 5'd5);
        r0    = mk(1, 0, 0, 0, 0, 0, 1, 3'd2, 5'd1, 5'd2, 5'd0);
        lw8   = mk(0, 0, 1, 1, 0, 1, 1, 3'd0, 5'd1, 5'd8, 5'd0);
        lw0   = mk(0, 0, 1, 1, 0, 1, 1, 3'd0, 5'd1, 5'd0, 5'd0);
        add8  = mk(1, 0, 0, 0, 0, 0, 1, 3'd2, 5'd8, 5'd3, 5'd4);
        rd0   = mk(1, 0, 0, 0, 0, 0, 1, 3'd2, 5'd0, 5'd3, 5'd6);
        rs9   = mk(1, 0, 0, 0, 0, 0, 1, 3'd2, 5'd9, 5'd10, 5'd11);
        beq   = mk(0, 1, 0, 0, 0, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        add   = mk(1, 0, 0, 0, 0, 0, 1, 3'd2, 5'd1, 5'd2, 5'd3);
        lwbr  = mk(0, 1, 1, 1, 0, 1, 1, 3'd1, 5'd1, 5'd8, 5'd0);
        sw    = mk(0, 0, 0, 0, 1, 1, 0, 3'd0, 5'd1, 5'd2, 5'd0);

        drive(ones, 1'b1);
        repeat (3) cyc(ones, 1'b1);
        chk("rst ex_valid", bus.ex_valid, 0);
        chk("rst mem_mem_write", bus.mem_mem_write, 0);
        chk("rst wb_reg_write", bus.wb_reg_write, 0);
        chk("rst stall", bus.stall, 0);
        chk("rst pc_src", bus.pc_src, 0);
        @(posedge clk);
        #1 drive(nop, 1'b0);
        rst_n = 1'b1;

        cyc(rtype, 0);
        cyc(nop, 0);
        chk("rtype ex_alu_op", bus.ex_alu_op, 7);
        chk("rtype ex_dst", bus.ex_dst, 5);
        cyc(nop, 0);
        cyc(nop, 0);
        chk("rtype wb_reg_write", bus.wb_reg_write, 1);
        chk("rtype wb_dst", bus.wb_dst, 5);

        cyc(lw8, 0);
        cyc(add8, 0);
        chk("lu stall", bus.stall, 1);
        cyc(add8, 0);
        chk("lu stall released", bus.stall, 0);
        chk("lu bubble", bus.ex_valid, 0);
        cyc(nop, 0);
        chk("lu add in ex", bus.ex_valid, 1);
        chk("lu add dst", bus.ex_dst, 4);

        cyc(lw0, 0);
        cyc(rd0, 0);
        chk("lw rt0 no stall", bus.stall, 0);
        cyc(lw8, 0);
        cyc(rs9, 0);
        chk("lw rt8 rs9 no stall", bus.stall, 0);

        cyc(beq, 0);
        cyc(add, 1);
        chk("taken pc_src", bus.pc_src, 1);
        chk("taken flush", bus.flush, 1);
        cyc(nop, 0);
        chk("taken bubble", bus.ex_valid, 0);
        cyc(beq, 0);
        cyc(add, 0);
        chk("not taken pc_src", bus.pc_src, 0);
        cyc(nop, 0);
        chk("not taken no bubble", bus.ex_valid, 1);

        cyc(lwbr, 0);
        cyc(add8, 1);
        chk("fvs flush", bus.flush, 1);
        chk("fvs stall", bus.stall, 0);
        cyc(nop, 0);
        chk("fvs bubble", bus.ex_valid, 0);

        cyc(beq, 0);
        cyc(beq, 1);
        chk("b2b first pc_src", bus.pc_src, 1);
        cyc(nop, 1);
        chk("b2b second pc_src", bus.pc_src, 0);

        cyc(r0, 0);
        cyc(nop, 0);
        cyc(nop, 0);
        cyc(nop, 0);
        chk("r0 wb_valid", bus.wb_valid, 1);
        chk("r0 wb_reg_write", bus.wb_reg_write, 0);

        cyc(sw, 0);
        cyc(nop, 0);
        cyc(nop, 0);
        chk("sw in mem", bus.mem_mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async mem_mem_write", bus.mem_mem_write, 0);
        chk("async mem_valid", bus.mem_valid, 0);
        cyc(nop, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(add, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
